// File: rtl/three_parallel_serializer_if.sv
// Block-in / sample-out bus of the 3-parallel output serializer.
// The master drives blocks and consumer ready; the slave is the serializer.
interface three_parallel_serializer_if #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_d1;
    logic signed [DATA_W-1:0] in_d2;
    logic signed [DATA_W-1:0] in_d3;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [1:0]               out_phase;
    logic                     out_sat;
    logic [15:0]              sat_count;

    modport master (
        output in_valid, in_d1, in_d2, in_d3, out_ready,
        input  in_ready, out_valid, out_data, out_phase, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_d1, in_d2, in_d3, out_ready,
        output in_ready, out_valid, out_data, out_phase, out_sat, sat_count
    );
endinterface

// File: rtl/three_parallel_serializer.sv
// Buffers 3-lane filter result blocks in a small FIFO and emits them one
// sample per transfer in lane order, saturating each sample to OUT_W bits.
module three_parallel_serializer #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    three_parallel_serializer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        PH_L1 = 2'd0,
        PH_L2 = 2'd1,
        PH_L3 = 2'd2
    } phase_e;

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] d3;
    } block_t;

    block_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    phase_e             phase_q, phase_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;

    logic                     in_ready;
    logic                     out_valid;
    logic                     push;
    logic                     xfer;
    logic                     pop;
    logic signed [DATA_W-1:0] lane_v;
    logic signed [OUT_W-1:0]  sat_v;
    logic                     sat_flag;

    // in_ready looks only at registered count, so no path from out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH)) && rst;
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign xfer      = out_valid && bus.out_ready;
    assign pop       = xfer && (phase_q == PH_L3);

    always_comb begin
        lane_v = mem_q[rd_ptr_q].d1;
        case (phase_q)
            PH_L2:   lane_v = mem_q[rd_ptr_q].d2;
            PH_L3:   lane_v = mem_q[rd_ptr_q].d3;
            default: lane_v = mem_q[rd_ptr_q].d1;
        endcase

        sat_flag = 1'b1;
        if (lane_v > SAT_MAX) begin
            sat_v = SAT_MAX[OUT_W-1:0];
        end else if (lane_v < SAT_MIN) begin
            sat_v = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_v    = lane_v[OUT_W-1:0];
            sat_flag = 1'b0;
        end
    end

    // NOTE: every variable gets a default first so this block can never infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        phase_d   = phase_q;
        sat_cnt_d = sat_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

        if (xfer) begin
            case (phase_q)
                PH_L1:   phase_d = PH_L2;
                PH_L2:   phase_d = PH_L3;
                default: phase_d = PH_L1;
            endcase
            if (sat_flag && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
        end

        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            phase_q   <= PH_L1;
            sat_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // NOTE: block storage has no reset; stale entries are never visible because count gates out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{d1: bus.in_d1, d2: bus.in_d2, d3: bus.in_d3};
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? sat_v : '0;
    assign bus.out_phase = out_valid ? phase_q : 2'd0;
    assign bus.out_sat   = out_valid && sat_flag;
    assign bus.sat_count = sat_cnt_q;
endmodule

// File: tb/tb_three_parallel_serializer.sv
// Scoreboard bench for three_parallel_serializer: accepted blocks expand into
// expected samples in a queue that a negedge monitor pops on each transfer.
module tb_three_parallel_serializer;
    localparam int DATA_W = 64;
    localparam int OUT_W  = 16;
    localparam int DEPTH  = 4;

    typedef struct {
        longint data;
        longint phase;
        longint sat;
    } sample_t;

    logic clk = 1'b0;
    logic rst;

    three_parallel_serializer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    three_parallel_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    sample_t exp_q[$];
    longint  model_sat = 0;
    bit      armed = 0;
    bit      stalled_prev = 0;
    longint  prev_data, prev_phase, prev_sat;
    bit      rand_done;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Saturation reference computed from the numeric range of an OUT_W-bit signed value.
    function automatic sample_t make_sample(input longint v, input int lane);
        longint hi;
        longint lo;
        sample_t s;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        s.phase = lane;
        if (v > hi) begin
            s.data = hi; s.sat = 1;
        end else if (v < lo) begin
            s.data = lo; s.sat = 1;
        end else begin
            s.data = v; s.sat = 0;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        int blocks;
        sample_t h;
        if (armed) begin
            blocks = (exp_q.size() + 2) / 3;
            check("in_ready", longint'(bus.in_ready), longint'(rst && (blocks != DEPTH)));
            check("out_valid", longint'(bus.out_valid), longint'(exp_q.size() != 0));
            if (bus.out_valid && exp_q.size() != 0) begin
                h = exp_q[0];
                check("out_data", longint'(bus.out_data), h.data);
                check("out_phase", longint'(bus.out_phase), h.phase);
                check("out_sat", longint'(bus.out_sat), h.sat);
            end else if (!bus.out_valid) begin
                check("idle_data", longint'(bus.out_data), 0);
                check("idle_phase", longint'(bus.out_phase), 0);
                check("idle_sat", longint'(bus.out_sat), 0);
            end
            if (stalled_prev && bus.out_valid) begin
                check("stall_data", longint'(bus.out_data), prev_data);
                check("stall_phase", longint'(bus.out_phase), prev_phase);
                check("stall_sat", longint'(bus.out_sat), prev_sat);
            end
            check("sat_count", longint'(bus.sat_count), model_sat);
            if (rst) begin
                if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                    h = exp_q.pop_front();
                    if (h.sat != 0 && model_sat != 65535) model_sat++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(make_sample(longint'(bus.in_d1), 0));
                    exp_q.push_back(make_sample(longint'(bus.in_d2), 1));
                    exp_q.push_back(make_sample(longint'(bus.in_d3), 2));
                end
            end
        end
        stalled_prev = rst && bus.out_valid && !bus.out_ready;
        prev_data  = longint'(bus.out_data);
        prev_phase = longint'(bus.out_phase);
        prev_sat   = longint'(bus.out_sat);
        if (!rst) begin
            armed = 1;
            exp_q.delete();
            model_sat = 0;
        end
    end

    task automatic push_block(input longint a, input longint b, input longint c);
        bus.in_valid = 1'b1;
        bus.in_d1 = a;
        bus.in_d2 = b;
        bus.in_d3 = c;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) return;
            @(posedge clk); #1;
        end
        check("drain_timeout", longint'(exp_q.size()), 0);
    endtask

    function automatic longint rand_val();
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 2000)) - 1000;
            1: return 32767 + longint'($urandom_range(0, 4)) - 2;
            2: return -32768 + longint'($urandom_range(0, 4)) - 2;
            default: return longint'({$urandom, $urandom});
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_d1 = 77; bus.in_d2 = 78; bus.in_d3 = 79;
        bus.out_ready = 1'b1;

        // Reset held with an offered block: nothing may be stored.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        push_block(5, -7, 100);
        wait_drain();

        // Fill to DEPTH with the consumer stalled, then offer one more.
        bus.out_ready = 1'b0;
        push_block(1, 2, 3);
        push_block(4, 5, 6);
        push_block(7, 8, 9);
        push_block(10, 11, 12);
        bus.in_valid = 1'b1;
        bus.in_d1 = 13; bus.in_d2 = 14; bus.in_d3 = 15;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", longint'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        push_block(13, 14, 15);
        wait_drain();

        push_block(40000, -40000, 32767);
        wait_drain();
        @(negedge clk);
        check("sat_count_two", longint'(bus.sat_count), 2);

        // Preload near the limit and confirm the count pins at 65535.
        @(posedge clk); #2;
        force dut.sat_cnt_q = 16'hFFFD;
        model_sat = 65533;
        @(negedge clk); #1;
        release dut.sat_cnt_q;
        @(posedge clk); #1;
        push_block(40000, -40000, 40000);
        wait_drain();
        @(negedge clk);
        check("sat_count_hold", longint'(bus.sat_count), 65535);
        @(posedge clk); #1;

        // Mid-block stall pattern on out_ready.
        bus.out_ready = 1'b0;
        push_block(10, 20, 30);
        begin
            bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 5; i++) begin
                bus.out_ready = pat[i];
                @(posedge clk); #1;
            end
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset part-way through a block discards everything buffered.
        bus.out_ready = 1'b0;
        push_block(101, 102, 103);
        push_block(104, 105, 106);
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", longint'(bus.out_valid), 0);
        check("post_rst_phase", longint'(bus.out_phase), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        push_block(1, 2, 3);
        wait_drain();

        // Random blocks against random consumer backpressure.
        rand_done = 0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    push_block(rand_val(), rand_val(), rand_val());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/three_parallel_serializer.md
# three_parallel_serializer

Output-side rate converter for the 3-parallel FIR datapath. Each cycle it may accept one block of three signed filter results (lanes 1, 2, 3 = consecutive output samples y(3k), y(3k+1), y(3k+2)) into a small block FIFO. It emits them as a single serial stream, one sample per transfer, in lane order. On the way out, each result is saturated to OUT_W bits. It sits between the parallel filter's output lanes and any single-sample-per-clock consumer (DAC interface, capture buffer).

## Interface
- DATA_W, 64: width of each parallel input lane (signed, matches filter outputs)
- OUT_W, 16: width of serial output sample (signed)
- DEPTH, 4: FIFO capacity in 3-sample blocks (power of 2, ≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  block FIFO can accept
- in_d1, in_d2, in_d3  in  DATA_W each  lanes 1..3, signed
- out_valid  out  1  serial sample available
- out_ready  in  1  consumer accepts sample
- out_data  out  OUT_W  saturated sample, signed
- out_phase  out  2  lane index of out_data (0,1,2)
- out_sat  out  1  out_data was clipped
- sat_count  out  16  saturating count of clipped samples transferred

## Operation
- Block push: in_valid && in_ready at a rising edge writes {in_d1,in_d2,in_d3} at the write pointer, and count += 1.
- in_ready = (count != DEPTH) && rst high. A push is never accepted into a full FIFO, even if a pop completes in the same cycle.
- out_valid = (count != 0). The head entry's lane is selected by the phase register (0→d1, 1→d2, 2→d3).
- Sample transfer: out_valid && out_ready.
  - Phase 0→1→2 advances by one per transfer.
  - The transfer at phase 2 returns phase to 0, advances the read pointer, and count -= 1.
- Simultaneous push and block pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Saturation, per selected lane value v:
  - v > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1, out_sat=1
  - v < -2^(OUT_W-1) → -2^(OUT_W-1), out_sat=1
  - otherwise, low OUT_W bits of v, out_sat=0
- out_data, out_sat and out_phase are all 0 whenever out_valid=0.
- sat_count increments on each transfer with out_sat=1 and holds at 16'hFFFF.
- Stall: while out_valid && !out_ready, out_data/out_phase/out_sat are held stable.
- Reset (rst=0 at an edge, including mid-block):
  - count, pointers, phase and sat_count go to 0.
  - Buffered data is discarded.
  - in_ready=0 while rst=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_phase=0, out_sat=0, sat_count=0, in_ready=0 (goes to 1 in the first cycle with rst=1).
- Latency: a block pushed at edge k into an empty FIFO gives out_valid=1 with lane 1 during cycle k+1 (combinational from storage, no extra register).
- Throughput: one sample per cycle with out_ready held high. Sustained input is therefore limited to one block per 3 cycles.
- in_ready depends only on registered count, with no combinational path from out_ready.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, sat_count=0, nothing stored. Release → in_ready=1 next cycle, out_valid stays 0.
- Single block: push d1=5, d2=-7, d3=100 with out_ready=1 → three consecutive cycles starting k+1 give out_data 5, -7, 100 with out_phase 0, 1, 2. Then out_valid=0 and in_ready=1 throughout.
- Fill/backpressure:
  - With out_ready=0, push blocks (1,2,3), (4,5,6), (7,8,9), (10,11,12) → in_ready=0 after the 4th; a 5th block offered is not accepted.
  - Set out_ready=1 → samples 1..12 emitted in order. The 5th block is accepted in the cycle after the phase-2 transfer of block 1.
- Saturation (OUT_W=16): push 40000, -40000, 32767 → output 32767/sat=1, -32768/sat=1, 32767/sat=0; sat_count=2. Repeat with sat_count preloaded near the limit (force) → it holds at 65535.
- Stall mid-block: push (10,20,30); toggle out_ready 1,0,0,1,1 → data 10, 20, 20, 20, 30 with out_phase 0, 1, 1, 1, 2. No sample duplicated or skipped at the consumer.
- Reset mid-stream:
  - Push 2 blocks, transfer 2 samples, then rst=0 for 1 cycle → out_valid=0, phase 0.
  - After release, push (1,2,3) → output begins with 1 at phase 0. No stale data appears.
